// File: rtl/dac_out_pio.sv
// dac_out_pio: Avalon-MM output PIO feeding a parallel DAC.
// Software pushes samples into a FIFO. A programmable divider pops one sample
// per DIVISOR+1 clocks onto out_port and pulses sample_strobe with the update.
// Optional build macro: DAC_OUT_PIO_IRQ_EN adds the irq output, CONTROL bit2
// (irq_mask) and STATUS bit12 (half-empty).
module dac_out_pio #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_WIDTH  = 16,
    parameter int DIV_RESET  = 999
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic                  sample_strobe
`ifdef DAC_OUT_PIO_IRQ_EN
    ,
    output logic                  irq
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0]        FULL_LVL = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0]        HALF_LVL = LW'(FIFO_DEPTH / 2);
    localparam logic [DIV_WIDTH-1:0] DIV_INIT = DIV_WIDTH'(DIV_RESET);

    // Bus decode
    logic wr;
    logic wr_data;
    logic wr_ctrl;
    logic wr_div;
    logic wr_stat;
    logic flush;

    // Control / status state
    logic                 enable;
    logic [DIV_WIDTH-1:0] divisor;
    logic [DIV_WIDTH-1:0] count;
    logic                 underflow;
    logic                 overflow;
    logic                 irq_mask;

    // Sample FIFO
    logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]         rd_ptr;
    logic [AW-1:0]         wr_ptr;
    logic [LW-1:0]         level;

    // Stage 0 (combinational) events evaluated in the current cycle
    logic tick_p0;
    logic pop_p0;
    logic push_ok;
    logic uf_set;
    logic of_set;
    logic half_empty;

    logic [31:0] rd_mux;
    logic        unused_bits;

    assign wr      = chipselect & ~write_n;
    assign wr_data = wr & (address == 2'd0);
    assign wr_ctrl = wr & (address == 2'd1);
    assign wr_div  = wr & (address == 2'd2);
    assign wr_stat = wr & (address == 2'd3);
    assign flush   = wr_ctrl & writedata[1];

    // A flush on the tick cycle suppresses the tick entirely.
    assign tick_p0    = enable & (count == '0) & ~flush;
    assign pop_p0     = tick_p0 & (level != '0);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok    = wr_data & ((level != FULL_LVL) | pop_p0);
    assign uf_set     = tick_p0 & (level == '0);
    assign of_set     = wr_data & ~push_ok;
    assign half_empty = (level <= HALF_LVL);

    assign unused_bits = ^writedata;

    // Divider: held at DIVISOR while disabled or flushed, reloads on reaching zero
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= DIV_INIT;
        end else if (flush || !enable || count == '0) begin
            count <= divisor;
        end else begin
            count <= count - DIV_WIDTH'(1);
        end
    end

    // Control registers: enable, divisor, sticky error flags
    always_ff @(posedge clk) begin
        if (reset) begin
            enable    <= 1'b0;
            divisor   <= DIV_INIT;
            underflow <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (wr_ctrl) enable <= writedata[0];
            if (wr_div)  divisor <= writedata[DIV_WIDTH-1:0];
            // A new event wins over a simultaneous write-1-to-clear.
            underflow <= uf_set | (underflow & ~(wr_stat & writedata[10]));
            overflow  <= of_set | (overflow & ~(wr_stat & writedata[11]));
        end
    end

    // FIFO storage write port (data only, no reset)
    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr] <= writedata[DATA_WIDTH-1:0];
    end

    // FIFO pointers and fill level
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_p0)  rd_ptr <= rd_ptr + AW'(1);
            if (push_ok && !pop_p0)      level <= level + LW'(1);
            else if (!push_ok && pop_p0) level <= level - LW'(1);
        end
    end

    // ---- stage 0 -> stage 1: popped head drives the DAC with a one-cycle strobe ----
    always_ff @(posedge clk) begin
        if (reset) begin
            out_port      <= '0;
            sample_strobe <= 1'b0;
        end else begin
            sample_strobe <= pop_p0;
            if (pop_p0) out_port <= fifo_mem[rd_ptr];
        end
    end

`ifdef DAC_OUT_PIO_IRQ_EN
    // Interrupt mask register and registered interrupt output
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_mask <= 1'b0;
            irq      <= 1'b0;
        end else begin
            if (wr_ctrl) irq_mask <= writedata[2];
            irq <= irq_mask & (half_empty | underflow);
        end
    end
`else
    assign irq_mask = 1'b0;
`endif

    // Read mux: register map decode, unused bits return zero
    always_comb begin
        rd_mux = '0;
        case (address)
            2'd0: rd_mux[DATA_WIDTH-1:0] = out_port;
            2'd1: begin
                rd_mux[0] = enable;
                rd_mux[2] = irq_mask;
            end
            2'd2: rd_mux[DIV_WIDTH-1:0] = divisor;
            default: begin
                rd_mux[7:0] = 8'(level);
                rd_mux[8]   = (level == '0);
                rd_mux[9]   = (level == FULL_LVL);
                rd_mux[10]  = underflow;
                rd_mux[11]  = overflow;
`ifdef DAC_OUT_PIO_IRQ_EN
                rd_mux[12]  = half_empty;
`else
                rd_mux[12]  = 1'b0 & half_empty;
`endif
            end
        endcase
    end

    // Registered read data, one cycle after the address
    always_ff @(posedge clk) begin
        if (reset) readdata <= '0;
        else       readdata <= rd_mux;
    end

endmodule

// File: tb/tb_dac_out_pio.sv
// tb_dac_out_pio: directed register-map scenarios followed by randomized bus
// traffic, checked every cycle against a queue-based behavioural model.
module tb_dac_out_pio;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic [7:0]  out_port;
    logic        sample_strobe;
`ifdef DAC_OUT_PIO_IRQ_EN
    logic        irq;
`endif

    always #5 clk = ~clk;

    dac_out_pio dut (
        .clk          (clk),
        .reset        (reset),
        .address      (address),
        .chipselect   (chipselect),
        .write_n      (write_n),
        .writedata    (writedata),
        .readdata     (readdata),
        .out_port     (out_port),
        .sample_strobe(sample_strobe)
`ifdef DAC_OUT_PIO_IRQ_EN
        ,
        .irq          (irq)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_live = 1'b0;
    bit          m_en, m_uf, m_of, m_mask, m_irq, m_strb;
    logic [15:0] m_div;
    int          m_cnt;
    logic [7:0]  q[$];
    logic [7:0]  m_out;
    logic [31:0] m_rd;

    function automatic logic [31:0] m_read(input logic [1:0] a);
        logic [31:0] v;
        v = 32'd0;
        case (a)
            2'd0: v = {24'd0, m_out};
            2'd1: v = {29'd0, m_mask, 1'b0, m_en};
            2'd2: v = {16'd0, m_div};
            default: begin
                v = 32'(q.size());
                if (q.size() == 0)     v[8] = 1'b1;
                if (q.size() == DEPTH) v[9] = 1'b1;
                v[10] = m_uf;
                v[11] = m_of;
`ifdef DAC_OUT_PIO_IRQ_EN
                v[12] = (q.size() <= DEPTH / 2);
`endif
            end
        endcase
        return v;
    endfunction

    // Model update on each edge, then compare the DUT against it
    always @(posedge clk) begin
        bit wr, flush, tick, uf_set, of_set, irq_next;
        if (reset) begin
            m_live = 1'b1;
            m_en = 0; m_div = 16'd999; m_cnt = 999; q.delete();
            m_out = 8'd0; m_strb = 0; m_rd = 32'd0;
            m_uf = 0; m_of = 0; m_mask = 0; m_irq = 0;
        end else if (m_live) begin
            wr       = chipselect && !write_n;
            flush    = wr && address == 2'd1 && writedata[1];
            tick     = m_en && m_cnt == 0 && !flush;
            m_rd     = m_read(address);
            irq_next = m_mask && (q.size() <= DEPTH / 2 || m_uf);
            m_strb = 0; uf_set = 0; of_set = 0;
            if (tick) begin
                if (q.size() == 0) uf_set = 1;
                else begin
                    m_out  = q.pop_front();
                    m_strb = 1;
                end
            end
            if (wr && address == 2'd0) begin
                if (q.size() < DEPTH) q.push_back(writedata[7:0]);
                else of_set = 1;
            end
            if (flush || !m_en || m_cnt == 0) m_cnt = int'(m_div);
            else m_cnt = m_cnt - 1;
            if (flush) q.delete();
            m_uf = uf_set || (m_uf && !(wr && address == 2'd3 && writedata[10]));
            m_of = of_set || (m_of && !(wr && address == 2'd3 && writedata[11]));
            if (wr && address == 2'd1) begin
                m_en = writedata[0];
`ifdef DAC_OUT_PIO_IRQ_EN
                m_mask = writedata[2];
`endif
            end
            if (wr && address == 2'd2) m_div = writedata[15:0];
            m_irq = irq_next;
        end
        #1;
        if (m_live) begin
            check("out_port", {24'd0, out_port}, {24'd0, m_out});
            check("sample_strobe", {31'd0, sample_strobe}, {31'd0, m_strb});
            check("readdata", readdata, m_rd);
`ifdef DAC_OUT_PIO_IRQ_EN
            check("irq", {31'd0, irq}, {31'd0, m_irq});
`endif
        end
    end

    // ---------------- stimulus helpers (called and returning at a negedge) ----------------
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
    endtask

    task automatic read_reg(input logic [1:0] a, output logic [31:0] v);
        address = a; chipselect = 1'b0; write_n = 1'b1;
        @(negedge clk);
        v = readdata;
    endtask

    logic [31:0] rv;
    int          st_t[$];
    logic [7:0]  st_v[$];

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset defaults
        check("rst out_port", {24'd0, out_port}, 32'd0);
        read_reg(2'd2, rv);
        check("rst divisor", rv, 32'h0000_03E7);
        check("model rst divisor", m_rd, 32'h0000_03E7);
        read_reg(2'd3, rv);
        check("rst status", rv, 32'h0000_0100);
        check("model rst status", m_rd, 32'h0000_0100);

        // Paced output
        bus_write(2'd2, 32'd3);
        bus_write(2'd0, 32'h11);
        bus_write(2'd0, 32'h22);
        bus_write(2'd0, 32'h33);
        bus_write(2'd1, 32'd1);
        st_t.delete(); st_v.delete();
        for (int c = 0; c < 40; c++) begin
            if (sample_strobe) begin st_t.push_back(c); st_v.push_back(out_port); end
            @(negedge clk);
        end
        check("paced strobe count", 32'(st_t.size()), 32'd3);
        if (st_t.size() == 3) begin
            check("paced first latency", 32'(st_t[0]), 32'd4);
            check("paced gap1", 32'(st_t[1] - st_t[0]), 32'd4);
            check("paced gap2", 32'(st_t[2] - st_t[1]), 32'd4);
            check("paced v0", {24'd0, st_v[0]}, 32'h11);
            check("paced v1", {24'd0, st_v[1]}, 32'h22);
            check("paced v2", {24'd0, st_v[2]}, 32'h33);
        end
        read_reg(2'd3, rv);
        check("underflow status", rv, 32'h0000_0500);
        bus_write(2'd1, 32'd0);
        bus_write(2'd3, 32'h0000_0C00);

        // Overflow
        for (int v = 0; v <= 16; v++) bus_write(2'd0, 32'(v));
        read_reg(2'd3, rv);
        check("overflow status", rv, 32'h0000_0A10);
        check("model overflow status", m_rd, 32'h0000_0A10);
        bus_write(2'd3, 32'h0000_0800);
        read_reg(2'd3, rv);
        check("overflow cleared", rv, 32'h0000_0210);

        // Full push with simultaneous pop
        bus_write(2'd2, 32'd0);
        bus_write(2'd1, 32'd1);
        bus_write(2'd0, 32'hAA);
        st_v.delete();
        for (int c = 0; c < 30; c++) begin
            if (sample_strobe) st_v.push_back(out_port);
            @(negedge clk);
        end
        check("full-pop strobe count", 32'(st_v.size()), 32'd17);
        if (st_v.size() == 17) begin
            check("full-pop first", {24'd0, st_v[0]}, 32'h00);
            check("full-pop 16th", {24'd0, st_v[15]}, 32'h0F);
            check("full-pop AA", {24'd0, st_v[16]}, 32'hAA);
        end
        read_reg(2'd3, rv);
        check("full-pop no overflow", rv & 32'h0000_0800, 32'd0);
        bus_write(2'd1, 32'd0);
        bus_write(2'd3, 32'h0000_0C00);

        // Flush on the tick cycle
        for (int v = 0; v < 5; v++) bus_write(2'd0, 32'h51 + 32'(v));
        bus_write(2'd1, 32'd1);
        bus_write(2'd1, 32'd3);
        check("flush no strobe", {31'd0, sample_strobe}, 32'd0);
        check("flush out_port held", {24'd0, out_port}, 32'hAA);
        read_reg(2'd3, rv);
        check("flush level", rv & 32'h0000_00FF, 32'd0);
        bus_write(2'd1, 32'd0);
        bus_write(2'd3, 32'h0000_0C00);

`ifdef DAC_OUT_PIO_IRQ_EN
        // Interrupt on half-empty
        bus_write(2'd2, 32'd3);
        bus_write(2'd1, 32'd4);
        for (int v = 0; v < 9; v++) bus_write(2'd0, 32'(v));
        repeat (2) @(negedge clk);
        check("irq level 9", {31'd0, irq}, 32'd0);
        bus_write(2'd1, 32'd5);
        begin
            int c;
            c = 0;
            while (!sample_strobe && c < 20) begin @(negedge clk); c++; end
            check("irq pop seen", {31'd0, sample_strobe}, 32'd1);
        end
        check("irq before lag", {31'd0, irq}, 32'd0);
        @(negedge clk);
        check("irq after pop", {31'd0, irq}, 32'd1);
        check("model irq after pop", {31'd0, m_irq}, 32'd1);
        bus_write(2'd1, 32'd0);
`endif

        // Reset in the middle of operation
        bus_write(2'd2, 32'd1);
        for (int v = 0; v < 4; v++) bus_write(2'd0, 32'hC0 + 32'(v));
        bus_write(2'd1, 32'd1);
        begin
            int c;
            c = 0;
            while (!sample_strobe && c < 10) begin @(negedge clk); c++; end
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst strobe", {31'd0, sample_strobe}, 32'd0);
        check("midrst out_port", {24'd0, out_port}, 32'd0);
        read_reg(2'd3, rv);
        check("midrst status", rv, 32'h0000_0100);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            int r;
            logic [31:0] d;
            r = int'($urandom_range(0, 99));
            reset = ($urandom_range(0, 399) == 0);
            address = 2'($urandom_range(0, 3));
            d = $urandom;
            if (r < 45) begin
                if (r < 20) address = 2'd0;
                if (address == 2'd2) d = 32'($urandom_range(0, 6));
                if (address == 2'd1) begin
                    d = 32'($urandom_range(0, 7));
                    if ($urandom_range(0, 7) != 0) d[1] = 1'b0;
                    if ($urandom_range(0, 3) != 0) d[0] = 1'b1;
                end
                chipselect = 1'b1; write_n = 1'b0; writedata = d;
            end else begin
                chipselect = 1'($urandom_range(0, 1));
                write_n = chipselect ? 1'b1 : 1'($urandom_range(0, 1));
                writedata = d;
            end
            @(negedge clk);
        end
        reset = 1'b0; chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
